// File: rtl/clock_set_ctrl_if.sv
// Key levels into the set-mode controller and its mode/command/blink outputs.
// master drives the keys (debounce side); slave is the controller.
interface clock_set_ctrl_if;
  logic [4:1] key_val;
  logic [1:0] mode;
  logic       run_en;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       blink;

  modport master (output key_val, input mode, run_en, inc_pulse, dec_pulse, blink);
  modport slave  (input key_val, output mode, run_en, inc_pulse, dec_pulse, blink);
endinterface

// File: rtl/clock_set_ctrl.sv
// Set-mode controller: RUN/SET_HOUR/SET_MIN/SET_SEC from key presses, inc/dec pulses with hold-to-repeat,
// run gating and blink. All outputs registered, 1 cycle after the sampled press; no backpressure.
module clock_set_ctrl #(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int TIMEOUT      = 500000000,
  parameter int BLINK_HALF   = 12500000
) (
  input logic             Clk_50MHz,
  input logic             Reset_N,
  clock_set_ctrl_if.slave bus
);

  localparam int RW = $clog2(REPEAT_DELAY);
  localparam int IW = $clog2(TIMEOUT);
  localparam int BW = $clog2(BLINK_HALF);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t        state_q, nxt_state;
  logic [4:1]    k_q, press;
  logic          run_en_q, inc_q, dec_q, blink_q;
  logic [RW-1:0] rep_cnt_q;
  logic          rep_act_q, rep_up_q, rep_dly_q;
  logic [IW-1:0] idle_q;
  logic [BW-1:0] blink_cnt_q;
  logic          in_set, up_low, dn_low, exit_go, mode_go, timeout_go, keys_ok;
  logic          up_go, dn_go, rep_keep, rep_fire, pulse;

  always_comb begin
    press      = k_q & ~bus.key_val;
    up_low     = ~bus.key_val[2];
    dn_low     = ~bus.key_val[3];
    in_set     = (state_q != RUN);
    exit_go    = in_set && press[4];
    mode_go    = !exit_go && press[1];
    timeout_go = in_set && (press == 4'b0) && (idle_q == IW'(TIMEOUT - 1));
    nxt_state  = state_q;
    if (exit_go || timeout_go)
      nxt_state = RUN;
    else if (mode_go)
      nxt_state = state_t'(state_q + 2'd1);
    // UP/DOWN only act when nothing of higher priority moved the state this cycle
    keys_ok  = in_set && (nxt_state == state_q);
    up_go    = keys_ok && press[2] && !dn_low;
    dn_go    = keys_ok && press[3] && !up_low;
    rep_keep = keys_ok && rep_act_q &&
               (rep_up_q ? (up_low && !dn_low) : (dn_low && !up_low));
    rep_fire = rep_keep &&
               (rep_cnt_q == (rep_dly_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));
    pulse    = up_go || dn_go || rep_fire;
  end

  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= RUN;
      run_en_q    <= 1'b1;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      blink_q     <= 1'b0;
      k_q         <= 4'hF;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_dly_q   <= 1'b0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
    end else begin
      k_q      <= bus.key_val;
      state_q  <= nxt_state;
      run_en_q <= (nxt_state == RUN);
      inc_q    <= up_go || (rep_fire && rep_up_q);
      dec_q    <= dn_go || (rep_fire && !rep_up_q);

      // Repeat only ever arms on a fresh press, so a key carried across a state change stays quiet
      if (up_go || dn_go) begin
        rep_act_q <= 1'b1;
        rep_up_q  <= up_go;
        rep_dly_q <= 1'b1;
        rep_cnt_q <= '0;
      end else if (rep_fire) begin
        rep_dly_q <= 1'b0;
        rep_cnt_q <= '0;
      end else if (rep_keep) begin
        if (rep_cnt_q != RW'(REPEAT_DELAY - 1))
          rep_cnt_q <= rep_cnt_q + RW'(1);
      end else begin
        rep_act_q <= 1'b0;
        rep_cnt_q <= '0;
      end

      if (!in_set || press != 4'b0 || pulse || nxt_state != state_q)
        idle_q <= '0;
      else if (idle_q != IW'(TIMEOUT - 1))
        idle_q <= idle_q + IW'(1);

      // Restart blink lit on every edit or entry so the new value is visible at once
      if (nxt_state == RUN) begin
        blink_q     <= 1'b0;
        blink_cnt_q <= '0;
      end else if (nxt_state != state_q || pulse) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_q     <= ~blink_q;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign bus.mode      = state_q;
  assign bus.run_en    = run_en_q;
  assign bus.inc_pulse = inc_q;
  assign bus.dec_pulse = dec_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios with literal expectations plus randomized keys,
// every cycle compared against a cycle-count based reference model.
module tb_clock_set_ctrl;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int TO = 100;
  localparam int BH = 8;
  localparam logic [4:1] K_NONE = 4'b1111;
  localparam logic [4:1] K_MODE = 4'b1110;
  localparam logic [4:1] K_UP   = 4'b1101;
  localparam logic [4:1] K_DN   = 4'b1011;
  localparam logic [4:1] K_EXIT = 4'b0111;

  logic Clk_50MHz = 1'b0;
  logic Reset_N   = 1'b0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .TIMEOUT     (TO),
    .BLINK_HALF  (BH)
  ) dut (
    .Clk_50MHz(Clk_50MHz),
    .Reset_N  (Reset_N),
    .bus      (bus)
  );

  always #10 Clk_50MHz = ~Clk_50MHz;

  int checks = 0;
  int errors = 0;

  // Reference model: everything expressed as cycle stamps measured from the event that started it
  int         t;
  int         last_act;
  int         rep_key;
  int         rep_t0;
  int         blink_ref;
  int         m_mode;
  logic       m_run, m_inc, m_dec, m_blink;
  logic [4:1] m_kprev;

  int exp_mode[4] = '{1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_run     = 1'b1;
    m_inc     = 1'b0;
    m_dec     = 1'b0;
    m_blink   = 1'b0;
    m_kprev   = 4'b1111;
    rep_key   = 0;
    last_act  = t;
    blink_ref = t;
  endtask

  task automatic model_step(input logic [4:1] k);
    logic [4:1] p;
    int         nxt;
    int         h;
    logic       up, dn, pulse;
    t++;
    p       = m_kprev & ~k;
    m_kprev = k;
    up      = !k[2];
    dn      = !k[3];
    nxt     = m_mode;
    m_inc   = 1'b0;
    m_dec   = 1'b0;
    if (m_mode == 0) begin
      if (p[1]) nxt = 1;
    end else if (p[4]) nxt = 0;
    else if (p[1]) nxt = (m_mode + 1) % 4;
    else if (p == 4'b0000 && t - last_act >= TO) nxt = 0;

    if (m_mode != 0 && nxt == m_mode) begin
      if (p[2] && !dn) begin
        m_inc = 1'b1; rep_key = 2; rep_t0 = t;
      end else if (p[3] && !up) begin
        m_dec = 1'b1; rep_key = 3; rep_t0 = t;
      end else if ((rep_key == 2 && up && !dn) || (rep_key == 3 && dn && !up)) begin
        h = t - rep_t0;
        if (h >= RD && (h - RD) % RR == 0) begin
          m_inc = (rep_key == 2);
          m_dec = (rep_key == 3);
        end
      end else rep_key = 0;
    end else rep_key = 0;

    pulse = m_inc | m_dec;
    if (m_mode == 0 || p != 4'b0000 || pulse || nxt != m_mode) last_act = t;
    if (nxt == 0) m_blink = 1'b0;
    else if (nxt != m_mode || pulse) begin
      blink_ref = t;
      m_blink   = 1'b1;
    end else m_blink = (((t - blink_ref) / BH) % 2) == 0;
    m_run  = (nxt == 0);
    m_mode = nxt;
  endtask

  task automatic compare();
    logic [5:0] a, e;
    a = {bus.mode, bus.run_en, bus.inc_pulse, bus.dec_pulse, bus.blink};
    e = {2'(m_mode), m_run, m_inc, m_dec, m_blink};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs t=%0d: got mode/run/inc/dec/blink=%b expected %b", t, a, e);
    end
  endtask

  task automatic cycle(input logic [4:1] k);
    bus.key_val = k;
    @(posedge Clk_50MHz);
    model_step(k);
    @(negedge Clk_50MHz);
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(K_NONE);
  endtask

  initial begin
    logic [63:0] mask;
    int          ndec, ninc, n;
    logic        b7, b8;

    bus.key_val = K_NONE;
    t = 0;
    model_reset();
    repeat (3) @(negedge Clk_50MHz);
    chk("reset_outputs", {bus.mode, bus.run_en, bus.inc_pulse, bus.dec_pulse, bus.blink}, 6'b001000);
    Reset_N = 1'b1;

    // Four MODE presses walk the states
    for (int i = 0; i < 4; i++) begin
      cycle(K_MODE);
      chk("mode_step", bus.mode, exp_mode[i]);
      chk("run_en_step", bus.run_en, (i == 3));
      cycle(K_MODE);
      cycle(K_MODE);
      idle(7);
    end

    // Hold UP 40 cycles in SET_MIN
    cycle(K_MODE); idle(2); cycle(K_MODE); idle(2);
    chk("in_set_min", bus.mode, 2);
    mask = '0;
    ndec = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(K_UP);
      if (bus.inc_pulse) mask[i] = 1'b1;
      if (bus.dec_pulse) ndec++;
    end
    cycle(K_NONE);
    chk("release_no_inc", bus.inc_pulse, 0);
    chk("repeat_mask", mask, 64'h0000_0008_4210_0001);
    chk("repeat_count", $countones(mask), 5);
    chk("repeat_no_dec", ndec, 0);
    cycle(K_EXIT);
    chk("exit_to_run", bus.mode, 0);
    idle(3);

    // UP/DOWN ignored in RUN; simultaneous UP+DOWN gives nothing in a set state
    cycle(K_UP);
    chk("run_up_no_inc", bus.inc_pulse, 0);
    idle(2);
    cycle(K_DN);
    chk("run_dn_no_dec", bus.dec_pulse, 0);
    chk("run_stays", bus.mode, 0);
    idle(2);
    cycle(K_MODE); idle(2);
    cycle(4'b1001);
    chk("both_no_pulse", {bus.inc_pulse, bus.dec_pulse}, 2'b00);
    repeat (25) cycle(4'b1001);
    idle(2);

    // Same-cycle priority
    cycle(K_MODE); idle(2); cycle(K_MODE); idle(2);
    chk("in_set_sec", bus.mode, 3);
    cycle(4'b0110);
    chk("exit_beats_mode", bus.mode, 0);
    idle(2);
    cycle(K_MODE); idle(2);
    cycle(4'b1100);
    chk("mode_beats_up", bus.mode, 2);
    chk("mode_beats_up_inc", bus.inc_pulse, 0);
    idle(2);
    cycle(K_EXIT); idle(2);

    // Idle timeout, with blink phase pinned
    cycle(K_MODE);
    n = 0; b7 = 1'b0; b8 = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      cycle(K_NONE);
      if (i == 7) b7 = bus.blink;
      if (i == 8) b8 = bus.blink;
      if (bus.mode == 2'd0) begin n = i; break; end
    end
    chk("timeout_cycles", n, 100);
    chk("timeout_run_en", bus.run_en, 1);
    chk("timeout_blink", bus.blink, 0);
    chk("blink_lit", b7, 1);
    chk("blink_dark", b8, 0);
    idle(3);
    cycle(K_MODE);
    idle(59);
    cycle(K_DN);
    chk("late_dec", bus.dec_pulse, 1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle(K_NONE);
      if (bus.mode == 2'd0) begin n = i; break; end
    end
    chk("timeout_after_press", n, 100);
    idle(3);

    // Asynchronous reset in the middle of a repeat
    cycle(K_MODE); idle(2); cycle(K_MODE); idle(2);
    repeat (21) cycle(K_UP);
    chk("pre_reset_inc", bus.inc_pulse, 1);
    #3 Reset_N = 1'b0;
    #1 chk("async_reset", {bus.mode, bus.run_en, bus.inc_pulse, bus.dec_pulse, bus.blink}, 6'b001000);
    @(posedge Clk_50MHz);
    @(negedge Clk_50MHz);
    Reset_N = 1'b1;
    model_reset();
    repeat (3) cycle(K_UP);
    chk("post_reset_no_inc", bus.inc_pulse, 0);
    cycle(4'b1100);
    chk("post_reset_mode", bus.mode, 1);
    ninc = 0;
    repeat (30) begin
      cycle(K_UP);
      if (bus.inc_pulse) ninc++;
    end
    chk("held_key_silent", ninc, 0);
    cycle(K_NONE);
    cycle(K_UP);
    chk("repress_inc", bus.inc_pulse, 1);
    idle(2);
    cycle(K_EXIT);
    idle(2);

    // Randomized key bursts
    for (int b = 0; b < 180; b++) begin
      logic [4:1] rk;
      int         len;
      rk = 4'b1111;
      if ($urandom_range(0, 5) == 0)  rk[1] = 1'b0;
      if ($urandom_range(0, 11) == 0) rk[4] = 1'b0;
      if ($urandom_range(0, 2) == 0)  rk[2] = 1'b0;
      if ($urandom_range(0, 2) == 0)  rk[3] = 1'b0;
      len = $urandom_range(1, 30);
      if (rk == 4'b1111 && $urandom_range(0, 3) == 0) len = $urandom_range(60, 130);
      repeat (len) cycle(rk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
